// File: rtl/led_display_package.sv
`default_nettype none
// ============================================================================
// Module      : led_display_package
// Description : Shared types and constants for the HUB75 LED row driver.
//               A row carries 64 pixels of 6 bits each, ordered
//               {r0,g0,b0,r1,g1,b1}, with pixel 0 in the most significant
//               bits. The top half-panel takes {r0,g0,b0} and the bottom
//               half-panel takes {r1,g1,b1}.
// Revision    : 1.0 - initial release
// ============================================================================
package led_display_package;

    localparam int GL_PANEL_W   = 64;
    localparam int GL_PIXEL_W   = 6;
    localparam int GL_RGB_ROW_W = GL_PANEL_W * GL_PIXEL_W;

    typedef logic [GL_RGB_ROW_W-1:0] rgb_row_t;
    typedef logic [GL_PIXEL_W-1:0]   pixel_t;

    typedef enum logic [2:0] {
        SS_IDLE    = 3'd0,
        SS_SHIFT   = 3'd1,
        SS_BLANK   = 3'd2,
        SS_LATCH   = 3'd3,
        SS_DISPLAY = 3'd4
    } state_t;

    // Colour bits for the top half-panel.
    function automatic logic [2:0] pixel_top(input pixel_t px);
        return px[5:3];
    endfunction

    // Colour bits for the bottom half-panel.
    function automatic logic [2:0] pixel_bot(input pixel_t px);
        return px[2:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_display_sclk_gen.sv
`default_nettype none
// ============================================================================
// Module      : led_display_sclk_gen
// Description : HUB75 shift-clock divider and pixel strobe. While enabled,
//               each pixel spends CLK_DIV cycles with sclk low followed by
//               CLK_DIV cycles with sclk high. All counters sit at zero while
//               disabled, so the first enabled cycle is the start of the low
//               phase of pixel 0.
// Ports       : clk_in         - clock
//               n_reset_in     - asynchronous active-low reset
//               i_enable       - high while the row is being shifted out
//               o_sclk         - shift clock, low whenever disabled
//               o_pixel_done   - last cycle of the current pixel
//               o_row_done     - last cycle of pixel 63
// Revision    : 1.0 - initial release
// ============================================================================
module led_display_sclk_gen
    import led_display_package::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk_in,
    input  logic n_reset_in,
    input  logic i_enable,
    output logic o_sclk,
    output logic o_pixel_done,
    output logic o_row_done
);

    // The divider needs to count up to 254 at most (CLK_DIV <= 255).
    localparam logic [7:0] c_DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [5:0] c_PIX_LAST = 6'(GL_PANEL_W - 1);

    logic [7:0] r_div;
    logic       r_phase;   // 0 = sclk low phase, 1 = sclk high phase
    logic [5:0] r_pix;
    logic       w_div_last;

    assign w_div_last = (r_div == c_DIV_LAST);

    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            r_div   <= 8'd0;
            r_phase <= 1'b0;
            r_pix   <= 6'd0;
        end else if (!i_enable) begin
            r_div   <= 8'd0;
            r_phase <= 1'b0;
            r_pix   <= 6'd0;
        end else if (w_div_last) begin
            r_div   <= 8'd0;
            r_phase <= ~r_phase;
            // Pixel index advances (and wraps 63 -> 0) at the end of the high phase.
            if (r_phase) begin
                r_pix <= r_pix + 6'd1;
            end
        end else begin
            r_div <= r_div + 8'd1;
        end
    end

    assign o_sclk       = r_phase & i_enable;
    assign o_pixel_done = i_enable & r_phase & w_div_last;
    assign o_row_done   = o_pixel_done & (r_pix == c_PIX_LAST);

endmodule
`default_nettype wire

// File: rtl/led_display_row_driver.sv
`default_nettype none
// ============================================================================
// Module      : led_display_row_driver
// Description : Drives one row of a HUB75 LED panel. A captured 384-bit row
//               is shifted out pixel by pixel (SS_SHIFT), the panel is
//               blanked (SS_BLANK), the row is latched and addressed
//               (SS_LATCH), then lit for OE_CYCLES cycles (SS_DISPLAY).
//               Build option: define LED_DISPLAY_ROW_DRIVER_DBUF_EN to add a
//               shadow row register so the next row can be accepted while the
//               current one is being shifted/displayed.
// Ports       : clk_in          - clock
//               n_reset_in      - asynchronous active-low reset
//               row_in          - row pixel data
//               row_valid_in    - one-cycle pulse qualifying row_in/address
//               row_address_in  - panel row index of row_in
//               row_ready_out   - driver can accept a row
//               rgb_top_out     - {r,g,b} for the top half-panel
//               rgb_bot_out     - {r,g,b} for the bottom half-panel
//               sclk_out        - HUB75 shift clock
//               latch_out       - HUB75 latch
//               n_oe_out        - HUB75 output enable, active low
//               addr_out        - HUB75 row address
// Revision    : 1.0 - initial release
// ============================================================================
module led_display_row_driver
    import led_display_package::*;
#(
    parameter int CLK_DIV      = 2,
    parameter int BLANK_CYCLES = 4,
    parameter int OE_CYCLES    = 256
) (
    input  logic       clk_in,
    input  logic       n_reset_in,
    input  rgb_row_t   row_in,
    input  logic       row_valid_in,
    input  logic [3:0] row_address_in,
    output logic       row_ready_out,
    output logic [2:0] rgb_top_out,
    output logic [2:0] rgb_bot_out,
    output logic       sclk_out,
    output logic       latch_out,
    output logic       n_oe_out,
    output logic [3:0] addr_out
);

    // One counter serves both timed states; size it for the longer of the two.
    localparam int c_CNT_MAX = (BLANK_CYCLES > OE_CYCLES) ? BLANK_CYCLES : OE_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_BLANK_LAST = c_CNT_W'(BLANK_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_OE_LAST    = c_CNT_W'(OE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);

    state_t             r_state;
    state_t             w_next_state;
    rgb_row_t           r_shift;
    logic [3:0]         r_row_addr;
    logic [3:0]         r_addr;
    logic [c_CNT_W-1:0] r_cnt;

    logic       w_ready;
    logic       w_start;
    logic       w_load;
    rgb_row_t   w_load_row;
    logic [3:0] w_load_addr;
    logic       w_sclk_en;
    logic       w_latch;
    logic       w_n_oe;
    logic       w_sclk;
    logic       w_pixel_done;
    logic       w_row_done;
    logic       w_shifting;

    // ------------------------------------------------------------------
    // Row intake
    // ------------------------------------------------------------------
`ifdef LED_DISPLAY_ROW_DRIVER_DBUF_EN
    rgb_row_t   r_shadow;
    logic [3:0] r_shadow_addr;
    logic       r_shadow_full;
    logic       w_capture;

    assign w_ready     = ~r_shadow_full;
    assign w_capture   = row_valid_in & row_ready_out;
    assign w_start     = r_shadow_full;
    assign w_load_row  = r_shadow;
    assign w_load_addr = r_shadow_addr;

    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            r_shadow      <= '0;
            r_shadow_addr <= 4'd0;
            r_shadow_full <= 1'b0;
        end else begin
            if (w_capture) begin
                r_shadow      <= row_in;
                r_shadow_addr <= row_address_in;
            end
            // A capture in the same cycle as a move refills the shadow.
            if (w_capture) begin
                r_shadow_full <= 1'b1;
            end else if (w_load) begin
                r_shadow_full <= 1'b0;
            end
        end
    end
`else
    assign w_ready     = (r_state == SS_IDLE);
    assign w_start     = row_valid_in & w_ready;
    assign w_load_row  = row_in;
    assign w_load_addr = row_address_in;
`endif

    // Gated by the reset pin so ready reads low during reset yet is high in
    // the very first cycle after release.
    assign row_ready_out = w_ready & n_reset_in;

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            r_state <= SS_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_sclk_en    = 1'b0;
        w_latch      = 1'b0;
        w_n_oe       = 1'b1;
        case (r_state)
            SS_IDLE: begin
                if (w_start) begin
                    w_load       = 1'b1;
                    w_next_state = SS_SHIFT;
                end
            end
            SS_SHIFT: begin
                w_sclk_en = 1'b1;
                if (w_row_done) begin
                    w_next_state = SS_BLANK;
                end
            end
            SS_BLANK: begin
                if (r_cnt == c_BLANK_LAST) begin
                    w_next_state = SS_LATCH;
                end
            end
            SS_LATCH: begin
                w_latch      = 1'b1;
                w_next_state = SS_DISPLAY;
            end
            SS_DISPLAY: begin
                w_n_oe = 1'b0;
                if (r_cnt == c_OE_LAST) begin
                    w_next_state = SS_IDLE;
                end
            end
            default: begin
                w_next_state = SS_IDLE;
            end
        endcase
    end

    // Cycle counter for SS_BLANK and SS_DISPLAY: zero on entry to each state
    // and held at zero elsewhere, so it never exceeds the longer duration.
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            r_cnt <= '0;
        end else if ((w_next_state != r_state) ||
                     ((r_state != SS_BLANK) && (r_state != SS_DISPLAY))) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Shift clock generation
    // ------------------------------------------------------------------
    led_display_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk_in       (clk_in),
        .n_reset_in   (n_reset_in),
        .i_enable     (w_sclk_en),
        .o_sclk       (w_sclk),
        .o_pixel_done (w_pixel_done),
        .o_row_done   (w_row_done)
    );

    // ------------------------------------------------------------------
    // Pixel shift buffer and row address
    // ------------------------------------------------------------------
    // The current pixel always sits in the top bits; shifting by one pixel
    // at the end of each high phase makes rgb change only at the start of
    // the following low phase.
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            r_shift    <= '0;
            r_row_addr <= 4'd0;
            r_addr     <= 4'd0;
        end else begin
            if (w_load) begin
                r_shift    <= w_load_row;
                r_row_addr <= w_load_addr;
            end else if (w_pixel_done) begin
                r_shift <= {r_shift[GL_RGB_ROW_W-GL_PIXEL_W-1:0], {GL_PIXEL_W{1'b0}}};
            end
            // Address changes on the edge into SS_LATCH so it is valid with
            // the latch pulse and held until the next latch.
            if ((r_state == SS_BLANK) && (w_next_state == SS_LATCH)) begin
                r_addr <= r_row_addr;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign w_shifting  = (r_state == SS_SHIFT);
    assign rgb_top_out = w_shifting ? pixel_top(r_shift[GL_RGB_ROW_W-1 -: GL_PIXEL_W]) : 3'b000;
    assign rgb_bot_out = w_shifting ? pixel_bot(r_shift[GL_RGB_ROW_W-1 -: GL_PIXEL_W]) : 3'b000;
    assign sclk_out    = w_sclk;
    assign latch_out   = w_latch;
    assign n_oe_out    = w_n_oe;
    assign addr_out    = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_led_display_row_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_display_row_driver
// Description : Self-checking bench for led_display_row_driver. Two instances
//               are exercised: CLK_DIV=2/BLANK=4/OE=256 and CLK_DIV=1/BLANK=2/
//               OE=16. Expected waveforms are computed per cycle from the
//               protocol timing with plain arithmetic on the offset from the
//               start of shifting.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_display_row_driver;
    import led_display_package::*;

    localparam int D0_CD = 2, D0_BL = 4, D0_OE = 256;
    localparam int D1_CD = 1, D1_BL = 2, D1_OE = 16;
    localparam logic [12:0] RESET_VEC = 13'b0_0_1_000_000_0000;
    localparam logic [12:0] NO_RGB    = 13'b1_1_1_000_000_1111;

    logic       clk = 1'b0;
    logic       n_reset;
    rgb_row_t   row_in;
    logic [3:0] row_addr;
    logic       valid0, valid1;

    logic       ready0, sclk0, latch0, noe0;
    logic [2:0] top0, bot0;
    logic [3:0] addr0;
    logic       ready1, sclk1, latch1, noe1;
    logic [2:0] top1, bot1;
    logic [3:0] addr1;

    int         total = 0;
    int         bad   = 0;
    logic [3:0] last_addr [2];
    logic [5:0] first_rise_rgb;

    always #5 clk = ~clk;

    led_display_row_driver #(.CLK_DIV(D0_CD), .BLANK_CYCLES(D0_BL), .OE_CYCLES(D0_OE)) dut0 (
        .clk_in(clk), .n_reset_in(n_reset), .row_in(row_in), .row_valid_in(valid0),
        .row_address_in(row_addr), .row_ready_out(ready0), .rgb_top_out(top0),
        .rgb_bot_out(bot0), .sclk_out(sclk0), .latch_out(latch0), .n_oe_out(noe0),
        .addr_out(addr0));

    led_display_row_driver #(.CLK_DIV(D1_CD), .BLANK_CYCLES(D1_BL), .OE_CYCLES(D1_OE)) dut1 (
        .clk_in(clk), .n_reset_in(n_reset), .row_in(row_in), .row_valid_in(valid1),
        .row_address_in(row_addr), .row_ready_out(ready1), .rgb_top_out(top1),
        .rgb_bot_out(bot1), .sclk_out(sclk1), .latch_out(latch1), .n_oe_out(noe1),
        .addr_out(addr1));

    function automatic logic [12:0] obs_vec(input int sel);
        return (sel == 0) ? {sclk0, latch0, noe0, top0, bot0, addr0}
                          : {sclk1, latch1, noe1, top1, bot1, addr1};
    endfunction

    function automatic logic obs_ready(input int sel);
        return (sel == 0) ? ready0 : ready1;
    endfunction

    function automatic rgb_row_t rand_row();
        rgb_row_t r;
        for (int i = 0; i < 12; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic set_valid(input int sel, input logic v);
        if (sel == 0) valid0 = v; else valid1 = v;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1 of an idle cycle; returns at posedge+1 of the first
    // SS_SHIFT cycle.
    task automatic send_row(input int sel, input rgb_row_t row, input logic [3:0] addr);
        row_in   = row;
        row_addr = addr;
        set_valid(sel, 1'b1);
        @(negedge clk);
        chk($sformatf("ready_at_capture%0d", sel), {15'b0, obs_ready(sel)}, 16'd1);
        @(posedge clk); #1;
        set_valid(sel, 1'b0);
`ifdef LED_DISPLAY_ROW_DRIVER_DBUF_EN
        @(negedge clk);
        chk($sformatf("ready_shadow_full%0d", sel), {15'b0, obs_ready(sel)}, 16'd0);
        @(posedge clk); #1;
`endif
    endtask

    // Checks a complete shift/blank/latch/display sequence, cycle by cycle.
    // Optionally pulses row_valid_in at offset inj_k with another row.
    task automatic check_seq(input int sel, input rgb_row_t row, input logic [3:0] addr,
                             input int inj_k, input rgb_row_t inj_row, input logic [3:0] inj_addr);
        int cd, bl, oe, shift_len, latch_k, seq_len, rises, latches, lit;
        logic [12:0] e, m, o;
        logic [5:0]  px;
        logic        prev_sclk, e_ready;
        cd = (sel == 0) ? D0_CD : D1_CD;
        bl = (sel == 0) ? D0_BL : D1_BL;
        oe = (sel == 0) ? D0_OE : D1_OE;
        shift_len = 128 * cd;
        latch_k   = shift_len + bl;
        seq_len   = latch_k + 1 + oe;
        rises = 0; latches = 0; lit = 0; prev_sclk = 1'b0;
        for (int k = 0; k < seq_len; k++) begin
            if (k == inj_k) begin
                row_in   = inj_row;
                row_addr = inj_addr;
                set_valid(sel, 1'b1);
            end else begin
                set_valid(sel, 1'b0);
            end
            @(negedge clk);
            m = 13'h1FFF;
            if (k < shift_len) begin
                px = row[383 - 6*(k/(2*cd)) -: 6];
                e  = {((k/cd) % 2 == 1), 1'b0, 1'b1, px, last_addr[sel]};
            end else if (k < latch_k) begin
                m = NO_RGB;
                e = {1'b0, 1'b0, 1'b1, 6'b0, last_addr[sel]};
            end else if (k == latch_k) begin
                m = NO_RGB;
                e = {1'b0, 1'b1, 1'b1, 6'b0, addr};
            end else begin
                m = NO_RGB;
                e = {1'b0, 1'b0, 1'b0, 6'b0, addr};
            end
`ifdef LED_DISPLAY_ROW_DRIVER_DBUF_EN
            e_ready = !((inj_k >= 0) && (k > inj_k));
`else
            e_ready = 1'b0;
`endif
            o = obs_vec(sel);
            chk($sformatf("seq%0d_k%0d", sel, k), {3'b0, o & m}, {3'b0, e & m});
            chk($sformatf("ready%0d_k%0d", sel, k), {15'b0, obs_ready(sel)}, {15'b0, e_ready});
            if (o[12] && !prev_sclk) begin
                rises++;
                if (rises == 1) first_rise_rgb = o[9:4];
            end
            prev_sclk = o[12];
            if (o[11]) latches++;
            if (!o[10]) lit++;
            @(posedge clk); #1;
        end
        set_valid(sel, 1'b0);
        last_addr[sel] = addr;
        chk($sformatf("sclk_rises%0d", sel), 16'(rises), 16'd64);
        chk($sformatf("latch_pulses%0d", sel), 16'(latches), 16'd1);
        chk($sformatf("oe_low_cycles%0d", sel), 16'(lit), 16'(oe));
    endtask

    // Idle: no shifting, panel dark, ready high, address held.
    task automatic idle_check(input int sel, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk($sformatf("idle%0d_%0d", sel, i), {3'b0, obs_vec(sel) & NO_RGB},
                {3'b0, 3'b001, 6'b0, last_addr[sel]});
            chk($sformatf("idle_ready%0d_%0d", sel, i), {15'b0, obs_ready(sel)}, 16'd1);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rgb_row_t r, r2;
        int       n_latch, n_sclk;
        n_reset  = 1'b0;
        valid0   = 1'b0;
        valid1   = 1'b0;
        row_in   = '0;
        row_addr = 4'd0;
        last_addr[0] = 4'd0;
        last_addr[1] = 4'd0;

        // Reset values while held in reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("in_reset_vec%0d", s), {3'b0, obs_vec(s)}, {3'b0, RESET_VEC});
            chk($sformatf("in_reset_ready%0d", s), {15'b0, obs_ready(s)}, 16'd0);
        end
        @(posedge clk); #1;
        n_reset = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("post_reset_ready%0d", s), {15'b0, obs_ready(s)}, 16'd1);
            chk($sformatf("post_reset_vec%0d", s), {3'b0, obs_vec(s) & NO_RGB}, {3'b0, RESET_VEC});
        end
        @(posedge clk); #1;

        // Directed row: pixel 0 = 101010, address 5
        r = rand_row();
        r[383 -: 6] = 6'b101010;
        send_row(0, r, 4'd5);
        check_seq(0, r, 4'd5, -1, '0, 4'd0);
        chk("first_rise_rgb", {10'b0, first_rise_rgb}, {10'b0, 6'b101010});
        idle_check(0, 3);

        // Row pulse while busy
        r  = rand_row();
        r2 = rand_row();
        send_row(0, r, 4'd9);
`ifdef LED_DISPLAY_ROW_DRIVER_DBUF_EN
        check_seq(0, r, 4'd9, 50, r2, 4'd3);
        @(negedge clk);
        chk("dbuf_idle_ready", {15'b0, ready0}, 16'd0);
        chk("dbuf_idle_vec", {3'b0, obs_vec(0) & NO_RGB}, {3'b0, 3'b001, 6'b0, 4'd9});
        @(posedge clk); #1;
        check_seq(0, r2, 4'd3, -1, '0, 4'd0);
        idle_check(0, 3);
`else
        check_seq(0, r, 4'd9, 128*D0_CD + D0_BL + 50, r2, 4'd3);
        idle_check(0, 20);
`endif

        // Random rows
        for (int i = 0; i < 2; i++) begin
            r = rand_row();
            row_addr = 4'($urandom_range(0, 15));
            send_row(0, r, row_addr);
            check_seq(0, r, row_addr, -1, '0, 4'd0);
        end

        // Reset in the middle of shifting
        r = rand_row();
        send_row(0, r, 4'd12);
        repeat (102) @(posedge clk);
        #1;
        chk("pre_reset_sclk_high", {15'b0, sclk0}, 16'd1);
        #2;
        n_reset = 1'b0;
        #1;
        chk("mid_reset_vec", {3'b0, obs_vec(0)}, {3'b0, RESET_VEC});
        chk("mid_reset_ready", {15'b0, ready0}, 16'd0);
        last_addr[0] = 4'd0;
        last_addr[1] = 4'd0;
        @(posedge clk); #1;
        n_reset = 1'b1;
        @(negedge clk);
        chk("release_ready", {15'b0, ready0}, 16'd1);
        @(posedge clk); #1;
        n_latch = 0;
        n_sclk  = 0;
        for (int i = 0; i < 128*D0_CD + D0_BL + 1 + D0_OE + 20; i++) begin
            @(negedge clk);
            if (latch0) n_latch++;
            if (sclk0)  n_sclk++;
            @(posedge clk); #1;
        end
        chk("no_latch_after_reset", 16'(n_latch), 16'd0);
        chk("no_sclk_after_reset", 16'(n_sclk), 16'd0);
        idle_check(0, 2);

        // CLK_DIV=1: addresses 15 then 0
        r  = rand_row();
        r2 = rand_row();
        send_row(1, r, 4'd15);
        check_seq(1, r, 4'd15, -1, '0, 4'd0);
        chk("addr_after_latch15", {12'b0, addr1}, 16'd15);
        send_row(1, r2, 4'd0);
        check_seq(1, r2, 4'd0, -1, '0, 4'd0);
        chk("addr_after_latch0", {12'b0, addr1}, 16'd0);
        idle_check(1, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led_display_row_driver.md
LED_DISPLAY_ROW_DRIVER -- requirements
Module: led_display_row_driver

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: system-clock cycles per sclk half-period, legal range 1..255.
REQ-002 SHALL have parameter BLANK_CYCLES, default 4: cycles n_oe is held high after the last pixel, before the latch, legal value 1 or more.
REQ-003 SHALL have parameter OE_CYCLES, default 256: cycles the panel is lit per row, legal value 1 or more.
REQ-004 SHALL have port clk_in, input, 1 bit: the single clock.
REQ-005 SHALL have port n_reset_in, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port row_in, input, rgb_row_t (GL_RGB_ROW_W = 384 bits): row pixel data.
REQ-007 SHALL have port row_valid_in, input, 1 bit: one-cycle pulse marking row_in and row_address_in valid.
REQ-008 SHALL have port row_address_in, input, 4 bits: panel row index belonging to row_in.
REQ-009 SHALL have port row_ready_out, output, 1 bit: the driver can accept a row.
REQ-010 SHALL have ports rgb_top_out and rgb_bot_out, output, 3 bits each: {r,g,b} for the top and bottom half-panel.
REQ-011 SHALL have ports sclk_out, latch_out and n_oe_out, output, 1 bit each: HUB75 shift clock, latch, and active-low output enable.
REQ-012 SHALL have port addr_out, output, 4 bits: HUB75 row address.

Function
REQ-013 SHALL map pixel p (0..63) to row_in bits [383-6p -: 6], ordered {r0,g0,b0,r1,g1,b1}; top = {r0,g0,b0}, bottom = {r1,g1,b1}.
REQ-014 SHALL implement FSM states SS_IDLE, SS_SHIFT, SS_BLANK, SS_LATCH, SS_DISPLAY.
REQ-015 SHALL, in SS_IDLE, hold row_ready_out high until row_valid_in is sampled high, then capture row_in and row_address_in and enter SS_SHIFT on the next cycle.
REQ-016 SHALL ignore row_valid_in while row_ready_out is low: no capture, no state change.
REQ-017 SHALL, in SS_SHIFT, shift out pixels 0 to 63 in order.
  - Each pixel: sclk_out low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - rgb outputs change only at the start of the low phase and stay stable through the high phase.
  - Total SS_SHIFT duration is exactly 128*CLK_DIV cycles.
REQ-018 SHALL return sclk_out low on leaving SS_SHIFT and hold it low in all other states.
REQ-019 SHALL hold n_oe_out high in every state except SS_DISPLAY.
REQ-020 SHALL stay in SS_BLANK for exactly BLANK_CYCLES cycles.
REQ-021 SHALL stay in SS_LATCH for exactly 1 cycle.
  - latch_out is high in that cycle only.
  - addr_out takes the captured row address in that same cycle.
REQ-022 SHALL, in SS_DISPLAY, drive n_oe_out low for exactly OE_CYCLES cycles, then enter SS_IDLE.
REQ-023 SHALL hold addr_out unchanged outside SS_LATCH; a row address wrap from 15 to 0 needs no special handling.
REQ-024 SHALL size all counters so that no count in the legal parameter range overflows.

Reset
REQ-025 SHALL, while n_reset_in is low, force asynchronously: state SS_IDLE, row_ready_out 0, rgb outputs 0, sclk_out 0, latch_out 0, n_oe_out 1, addr_out 0.
REQ-026 SHALL, on reset mid-operation, discard any captured row and pending shadow row; the first cycle after reset release is SS_IDLE with row_ready_out 1.

Configuration
REQ-027 SHALL, with macro LED_DISPLAY_ROW_DRIVER_DBUF_EN defined, add a shadow row register.
  - row_ready_out = !shadow_full, in any state.
  - A row is captured into the shadow on row_valid_in && row_ready_out.
  - In SS_IDLE with the shadow full, the shadow moves to the shift buffer and the shadow empties; SS_SHIFT is entered next cycle.
  - If a capture and a move occur in the same cycle, the shadow ends full with the new row.
REQ-028 SHALL, with LED_DISPLAY_ROW_DRIVER_DBUF_EN undefined, have no shadow register and behave per REQ-015/016 (row_ready_out high only in SS_IDLE).

Structure
REQ-029 SHALL take from led_display_package: rgb_row_t, GL_RGB_ROW_W, GL_PANEL_W = 64, GL_PIXEL_W = 6, and the driver state_t enum.
REQ-030 SHALL place the sclk divider and pixel strobe in one sub-module, led_display_sclk_gen.

Verification
REQ-031 SHALL cover reset release: row_ready_out 1 the cycle after release, n_oe_out 1, addr_out 0.
REQ-032 SHALL cover a single row (CLK_DIV=2, pixel 0 = 6'b101010, row_address_in=5):
  - rgb_top_out=3'b101 and rgb_bot_out=3'b010 at the first sclk rise.
  - Exactly 64 sclk rises.
  - latch_out pulse 260 cycles after SS_SHIFT entry, with addr_out=5.
  - n_oe_out low for 256 cycles.
REQ-033 SHALL cover a row_valid_in pulse during SS_DISPLAY with DBUF undefined: pulse ignored, no second shift sequence.
REQ-034 SHALL cover a row_valid_in pulse during SS_SHIFT with DBUF defined:
  - row_ready_out drops.
  - A second SS_SHIFT starts 1 cycle after SS_IDLE entry.
REQ-035 SHALL cover reset asserted midway through SS_SHIFT: outputs return to reset values immediately, and no latch occurs afterwards.
REQ-036 SHALL cover CLK_DIV=1 with row_address_in=15 then 0: sclk period 2 cycles, addr_out 15 then 0 after the two latches.
